// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, mux/ALU codes, control bundle.
// The addi path is enabled by defining MC_IMM_OPS_EN.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Next-state and Moore output decode for the multicycle controller.
// Defining MC_IMM_OPS_EN adds the ADDIEX/ADDIWB path; otherwise addi traps.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPW      = 6,
    parameter int unsigned MEM_WAIT = 1
) (
    input  state_t         state,
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] op_latched,
    input  logic           mem_ready,
    output state_t         next_state,
    output ctrl_t          ctrl
);

    localparam logic [OPW-1:0] C_RTYPE = OPW'(OP_RTYPE);
    localparam logic [OPW-1:0] C_LW    = OPW'(OP_LW);
    localparam logic [OPW-1:0] C_SW    = OPW'(OP_SW);
    localparam logic [OPW-1:0] C_BEQ   = OPW'(OP_BEQ);
    localparam logic [OPW-1:0] C_J     = OPW'(OP_J);
    localparam logic [OPW-1:0] C_ADDI  = OPW'(OP_ADDI);

    // Memory states may only leave once the access completes
    logic mem_go;
    assign mem_go = mem_ready || (MEM_WAIT == 0);

    always_comb begin
        next_state = S_FETCH;
        ctrl       = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.pc_write  = mem_go;
                next_state     = mem_go ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    C_LW, C_SW: next_state = S_MEMADR;
                    C_RTYPE:    next_state = S_EXEC;
                    C_BEQ:      next_state = S_BRANCH;
                    C_J:        next_state = S_JUMP;
`ifdef MC_IMM_OPS_EN
                    C_ADDI:     next_state = S_ADDIEX;
`else
                    C_ADDI:     next_state = S_TRAP;
`endif
                    default:    next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                next_state     = (op_latched == C_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                next_state    = mem_go ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                next_state     = mem_go ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
                next_state     = S_RWB;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
`ifdef MC_IMM_OPS_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                next_state     = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            S_TRAP: begin
                ctrl.illegal_op = 1'b1;
            end
            // Unused encodings behave like TRAP and recover to FETCH
            default: begin
                ctrl.illegal_op = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mc_fsm_controller.sv
// Multicycle datapath controller: state register and opcode latch around mc_ctrl_decode.
// Build with MC_IMM_OPS_EN defined to enable the addi path.
module mc_fsm_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPW      = 6,
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic           AluSrcA,
    output logic           RegWrite,
    output logic           RegDst,
    output logic [1:0]     PCSrc,
    output logic [1:0]     AluOp,
    output logic [1:0]     AluSrcB,
    output logic [3:0]     state,
    output logic           illegal_op
);

    state_t         state_q;
    state_t         state_d;
    logic [OPW-1:0] op_q;
    ctrl_t          ctrl;
    ctrl_t          ctrl_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    mc_ctrl_decode #(
        .OPW      (OPW),
        .MEM_WAIT (MEM_WAIT)
    ) u_decode (
        .state      (state_q),
        .opcode     (opcode),
        .op_latched (op_q),
        .mem_ready  (mem_ready),
        .next_state (state_d),
        .ctrl       (ctrl)
    );

    // Reset silences the datapath immediately, even mid-instruction
    assign ctrl_out = reset ? '0 : ctrl;

    assign PCWrite     = ctrl_out.pc_write;
    assign PCWriteCond = ctrl_out.pc_write_cond;
    assign IorD        = ctrl_out.i_or_d;
    assign MemRead     = ctrl_out.mem_read;
    assign MemWrite    = ctrl_out.mem_write;
    assign IRWrite     = ctrl_out.ir_write;
    assign MemtoReg    = ctrl_out.mem_to_reg;
    assign AluSrcA     = ctrl_out.alu_src_a;
    assign RegWrite    = ctrl_out.reg_write;
    assign RegDst      = ctrl_out.reg_dst;
    assign PCSrc       = ctrl_out.pc_src;
    assign AluOp       = ctrl_out.alu_op;
    assign AluSrcB     = ctrl_out.alu_src_b;
    assign illegal_op  = ctrl_out.illegal_op;
    assign state       = state_q;

endmodule
